// File: rtl/au_op_sequencer_pkg.sv
// Shared opcode/error encodings, FSM states and the queued command format
// for the ALU op sequencer.
package au_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [1:0] ERR_OK   = 2'b00;
   localparam logic [1:0] ERR_DIV0 = 2'b01;
   localparam logic [1:0] ERR_TMO  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } seq_state_e;

   typedef struct packed {
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] ctrl;
   } au_cmd_t;

   function automatic logic is_div0(input au_cmd_t c);
      return (c.ctrl == OP_DIV) && (c.b == 2'b00);
   endfunction

endpackage

// File: rtl/au_op_sequencer_if.sv
// Command, ALU and response signals of the sequencer. master is the
// surrounding environment (upstream, ALU, downstream); slave is the sequencer.
interface au_op_sequencer_if;
   import au_pkg::*;

   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_a;
   logic [1:0] cmd_b;
   logic [1:0] cmd_ctrl;
   logic [1:0] alu_a;
   logic [1:0] alu_b;
   logic [1:0] alu_ctrl;
   logic [3:0] alu_y;
   logic       alu_c;
   logic       alu_done;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_y;
   logic       rsp_c;
   logic [1:0] rsp_err;
   logic       busy;

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_ctrl, alu_y, alu_c, alu_done, rsp_ready,
      input  cmd_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_y, rsp_c, rsp_err, busy
   );

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_ctrl, alu_y, alu_c, alu_done, rsp_ready,
      output cmd_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_y, rsp_c, rsp_err, busy
   );

endinterface

// File: rtl/au_op_sequencer_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so the pointers
// wrap naturally. Head entry is visible on rd_data whenever not empty.
module au_cmd_fifo
   import au_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = $bits(au_cmd_t)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + (AW+1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);

endmodule

// File: rtl/au_op_sequencer.sv
// Requesting end of the multi-cycle ALU: queues commands, issues them one at a
// time, answers divide-by-zero locally and bounds the wait for alu_done.
module au_op_sequencer
   import au_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   au_op_sequencer_if.slave bus
);
   // state    | meaning
   // ST_IDLE  | pop and classify the queue head, if any
   // ST_ISSUE | operands newly on alu_*, alu_done is stale and ignored
   // ST_WAIT  | waiting for alu_done, timeout timer running
   // ST_RESP  | result held on rsp_* until rsp_ready
   localparam int TW = $clog2(TIMEOUT);

   seq_state_e    state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [1:0]    alu_a_q, alu_a_d;
   logic [1:0]    alu_b_q, alu_b_d;
   logic [1:0]    alu_ctrl_q, alu_ctrl_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [3:0]    rsp_y_q, rsp_y_d;
   logic          rsp_c_q, rsp_c_d;
   logic [1:0]    rsp_err_q, rsp_err_d;
   au_cmd_t       cmd_in, head;
   logic          push, pop, fifo_full, fifo_empty;

   assign cmd_in = '{a: bus.cmd_a, b: bus.cmd_b, ctrl: bus.cmd_ctrl};
   assign push   = bus.cmd_valid && !fifo_full;

   au_cmd_fifo #(.DEPTH(DEPTH), .WIDTH($bits(au_cmd_t))) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .wr_data (cmd_in),
      .pop     (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_ctrl_d  = alu_ctrl_q;
      rsp_valid_d = rsp_valid_q;
      rsp_y_d     = rsp_y_q;
      rsp_c_d     = rsp_c_q;
      rsp_err_d   = rsp_err_q;
      pop         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (is_div0(head)) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_y_d     = '0;
                  rsp_c_d     = 1'b0;
                  rsp_err_d   = ERR_DIV0;
               end else begin
                  state_d    = ST_ISSUE;
                  alu_a_d    = head.a;
                  alu_b_d    = head.b;
                  alu_ctrl_d = head.ctrl;
               end
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
            tmr_d   = TW'(TIMEOUT - 1);
         end
         ST_WAIT: begin
            // Done is checked first so a completion on the last allowed cycle wins.
            if (bus.alu_done) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_y_d     = bus.alu_y;
               rsp_c_d     = bus.alu_c;
               rsp_err_d   = ERR_OK;
            end else if (tmr_q == '0) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_y_d     = '0;
               rsp_c_d     = 1'b0;
               rsp_err_d   = ERR_TMO;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         tmr_q       <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_ctrl_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_y_q     <= '0;
         rsp_c_q     <= 1'b0;
         rsp_err_q   <= ERR_OK;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_ctrl_q  <= alu_ctrl_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_y_q     <= rsp_y_d;
         rsp_c_q     <= rsp_c_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.cmd_ready = !fifo_full;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_ctrl  = alu_ctrl_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_y     = rsp_y_q;
   assign bus.rsp_c     = rsp_c_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_au_op_sequencer.sv
// Directed bench for au_op_sequencer: a combinational ALU stand-in supplies
// alu_y/alu_c, while alu_done is driven step by step.
module tb_au_op_sequencer;
   import au_pkg::*;

   localparam int TIMEOUT = 15;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   errors = 0;
   int   checks = 0;
   logic accepted6;
   logic stale;
   int   n;
   logic [5:0] t4_cmd [6];
   logic [3:0] t4_y   [6];
   logic       t4_c   [6];
   logic [1:0] t4_err [6];

   au_op_sequencer_if bus ();

   au_op_sequencer #(.DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ALU stand-in: result is a pure function of the presented operands.
   always_comb begin
      bus.alu_c = 1'b0;
      bus.alu_y = 4'h0;
      case (bus.alu_ctrl)
         OP_ADD: bus.alu_y = {2'b00, bus.alu_a} + {2'b00, bus.alu_b};
         OP_SUB: begin
            bus.alu_y = {2'b00, bus.alu_a} - {2'b00, bus.alu_b};
            bus.alu_c = (bus.alu_a < bus.alu_b);
         end
         OP_MUL: bus.alu_y = {2'b00, bus.alu_a} * {2'b00, bus.alu_b};
         default: bus.alu_y = (bus.alu_b == 2'b00) ? 4'h0 : ({2'b00, bus.alu_a} / {2'b00, bus.alu_b});
      endcase
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic drive_cmd(input logic [1:0] a, input logic [1:0] b, input logic [1:0] ctrl);
      bus.cmd_valid = 1'b1;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_ctrl  = ctrl;
   endtask

   // Step once, dropping cmd_valid if the presented command was taken at that edge.
   task automatic adv();
      logic acc;
      acc = bus.cmd_valid && bus.cmd_ready;
      step();
      if (acc) begin
         bus.cmd_valid = 1'b0;
         accepted6     = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_a     = 2'b00;
      bus.cmd_b     = 2'b00;
      bus.cmd_ctrl  = 2'b00;
      bus.alu_done  = 1'b0;
      bus.rsp_ready = 1'b0;
      t4_cmd = '{6'b011000, 6'b011101, 6'b111110, 6'b110111, 6'b100011, 6'b111001};
      t4_y   = '{4'h3, 4'hE, 4'h9, 4'h3, 4'h0, 4'h1};
      t4_c   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      t4_err = '{ERR_OK, ERR_OK, ERR_OK, ERR_OK, ERR_DIV0, ERR_OK};

      step();
      step();
      chk("rst_rsp_valid", bus.rsp_valid, 8'd0);
      chk("rst_alu_a", bus.alu_a, 8'd0);
      chk("rst_busy", bus.busy, 8'd0);
      reset = 1'b1;
      step();
      chk("rel_cmd_ready", bus.cmd_ready, 8'd1);
      chk("rel_rsp_err", bus.rsp_err, 8'd0);
      chk("rel_rsp_y", bus.rsp_y, 8'd0);

      // 1: ADD 10+01, done on the first WAIT cycle
      drive_cmd(2'b10, 2'b01, OP_ADD);
      step();
      bus.cmd_valid = 1'b0;
      step();
      chk("t1_alu_a", bus.alu_a, 8'h2);
      chk("t1_alu_b", bus.alu_b, 8'h1);
      chk("t1_alu_ctrl", bus.alu_ctrl, 8'h0);
      chk("t1_busy", bus.busy, 8'd1);
      step();
      chk("t1_no_rsp_yet", bus.rsp_valid, 8'd0);
      bus.alu_done = 1'b1;
      step();
      bus.alu_done = 1'b0;
      chk("t1_rsp_valid", bus.rsp_valid, 8'd1);
      chk("t1_rsp_y", bus.rsp_y, 8'h3);
      chk("t1_rsp_c", bus.rsp_c, 8'h0);
      chk("t1_rsp_err", bus.rsp_err, 8'h0);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      chk("t1_rsp_drop", bus.rsp_valid, 8'd0);
      chk("t1_idle", bus.busy, 8'd0);

      // 2: DIV by zero answered one cycle after the pop, ALU untouched
      drive_cmd(2'b10, 2'b00, OP_DIV);
      step();
      bus.cmd_valid = 1'b0;
      step();
      chk("t2_rsp_valid", bus.rsp_valid, 8'd1);
      chk("t2_rsp_err", bus.rsp_err, 8'h1);
      chk("t2_rsp_y", bus.rsp_y, 8'h0);
      chk("t2_alu_a", bus.alu_a, 8'h2);
      chk("t2_alu_b", bus.alu_b, 8'h1);
      chk("t2_alu_ctrl", bus.alu_ctrl, 8'h0);
      step();
      chk("t2_rsp_hold", bus.rsp_valid, 8'd1);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      chk("t2_rsp_drop", bus.rsp_valid, 8'd0);

      // 3: MUL times out, queued SUB then completes
      drive_cmd(2'b10, 2'b11, OP_MUL);
      step();
      drive_cmd(2'b11, 2'b01, OP_SUB);
      step();
      bus.cmd_valid = 1'b0;
      bus.alu_done  = 1'b1;
      step();
      bus.alu_done = 1'b0;
      chk("t3_alu_ctrl", bus.alu_ctrl, 8'h2);
      chk("t3_alu_b", bus.alu_b, 8'h3);
      for (int i = 0; i < TIMEOUT - 1; i++) step();
      chk("t3_no_rsp_before_tmo", bus.rsp_valid, 8'd0);
      step();
      chk("t3_tmo_valid", bus.rsp_valid, 8'd1);
      chk("t3_tmo_err", bus.rsp_err, 8'h2);
      chk("t3_tmo_y", bus.rsp_y, 8'h0);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      step();
      chk("t3_sub_alu_a", bus.alu_a, 8'h3);
      chk("t3_sub_alu_ctrl", bus.alu_ctrl, 8'h1);
      step();
      bus.alu_done = 1'b1;
      step();
      bus.alu_done = 1'b0;
      chk("t3_sub_valid", bus.rsp_valid, 8'd1);
      chk("t3_sub_y", bus.rsp_y, 8'h2);
      chk("t3_sub_err", bus.rsp_err, 8'h0);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      chk("t3_sub_drop", bus.rsp_valid, 8'd0);

      // 4: fill with rsp_ready low, then drain in order
      bus.alu_done = 1'b1;
      accepted6    = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive_cmd(t4_cmd[k][5:4], t4_cmd[k][3:2], t4_cmd[k][1:0]);
         chk("t4_ready_fill", bus.cmd_ready, 8'd1);
         step();
      end
      drive_cmd(t4_cmd[5][5:4], t4_cmd[5][3:2], t4_cmd[5][1:0]);
      chk("t4_full_ready", bus.cmd_ready, 8'd0);
      step();
      chk("t4_full_hold", bus.cmd_ready, 8'd0);
      bus.rsp_ready = 1'b1;
      for (int r = 0; r < 6; r++) begin
         n = 0;
         while (!bus.rsp_valid && n < 30) begin
            adv();
            n++;
         end
         chk("t4_rsp_seen", bus.rsp_valid, 8'd1);
         chk("t4_rsp_y", bus.rsp_y, 8'(t4_y[r]));
         chk("t4_rsp_c", bus.rsp_c, 8'(t4_c[r]));
         chk("t4_rsp_err", bus.rsp_err, 8'(t4_err[r]));
         adv();
      end
      chk("t4_sixth_accepted", accepted6, 8'd1);
      chk("t4_ready_back", bus.cmd_ready, 8'd1);
      bus.rsp_ready = 1'b0;
      bus.alu_done  = 1'b0;
      step();
      chk("t4_idle", bus.busy, 8'd0);

      // 5: reset during WAIT with two commands queued
      drive_cmd(2'b10, 2'b11, OP_MUL);
      step();
      drive_cmd(2'b01, 2'b01, OP_ADD);
      step();
      drive_cmd(2'b10, 2'b10, OP_ADD);
      step();
      bus.cmd_valid = 1'b0;
      step();
      chk("t5_pre_alu_a", bus.alu_a, 8'h2);
      reset = 1'b0;
      #1;
      chk("t5_rst_alu_a", bus.alu_a, 8'h0);
      chk("t5_rst_alu_b", bus.alu_b, 8'h0);
      chk("t5_rst_alu_ctrl", bus.alu_ctrl, 8'h0);
      chk("t5_rst_rsp_y", bus.rsp_y, 8'h0);
      chk("t5_rst_busy", bus.busy, 8'd0);
      step();
      step();
      reset = 1'b1;
      step();
      chk("t5_rel_busy", bus.busy, 8'd0);
      chk("t5_rel_ready", bus.cmd_ready, 8'd1);
      bus.alu_done = 1'b1;
      stale = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.rsp_valid || bus.busy) stale = 1'b1;
      end
      bus.alu_done = 1'b0;
      chk("t5_no_stale", stale, 8'd0);

      // 6: done arrives on the last allowed WAIT cycle
      drive_cmd(2'b10, 2'b11, OP_MUL);
      step();
      bus.cmd_valid = 1'b0;
      step();
      step();
      for (int i = 0; i < TIMEOUT - 1; i++) step();
      chk("t6_no_rsp_yet", bus.rsp_valid, 8'd0);
      bus.alu_done = 1'b1;
      step();
      bus.alu_done = 1'b0;
      chk("t6_valid", bus.rsp_valid, 8'd1);
      chk("t6_err", bus.rsp_err, 8'h0);
      chk("t6_y", bus.rsp_y, 8'h6);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      chk("t6_drop", bus.rsp_valid, 8'd0);
      chk("t6_idle", bus.busy, 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/au_op_sequencer.md
Name: au_op_sequencer

Overview:
- Initiator for the multi-cycle ALU (`au`): it is the requesting end of the a/b/ctrl → y/c/done interface.
- Accepts ALU commands from upstream over a valid/ready port and buffers them in a small FIFO.
- Issues one command at a time to the ALU, holding the operands until `done`, then returns the result downstream over valid/ready.
- Catches divide-by-zero locally (without issuing it to the ALU) and reports a timeout if `done` never arrives.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, ≥2)
- TIMEOUT, 15, maximum cycles spent in WAIT before an error is reported (≥2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  upstream command valid
- cmd_ready  out  1  FIFO can accept a command (= !full)
- cmd_a  in  2  operand a
- cmd_b  in  2  operand b
- cmd_ctrl  in  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV
- alu_a  out  2  operand a driven to the ALU
- alu_b  out  2  operand b driven to the ALU
- alu_ctrl  out  2  opcode driven to the ALU
- alu_y  in  4  ALU result
- alu_c  in  1  ALU carry/flag
- alu_done  in  1  ALU completion
- rsp_valid  out  1  result valid
- rsp_ready  in  1  downstream accepts the result
- rsp_y  out  4  result value
- rsp_c  out  1  result carry/flag
- rsp_err  out  2  00 ok, 01 divide-by-zero, 10 timeout
- busy  out  1  FSM not in IDLE, or FIFO not empty

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied and FSM forced to IDLE.
  - alu_a/alu_b/alu_ctrl = 0.
  - rsp_valid = 0, rsp_y = 0, rsp_c = 0, rsp_err = 0, busy = 0.
  - cmd_ready = 1 in the first cycle after release.
  - Applies identically mid-operation; the in-flight command is discarded.
- FIFO:
  - Push on cmd_valid && cmd_ready.
  - Pop only in IDLE when non-empty.
  - Push and pop in the same cycle are both honoured and the count is unchanged.
  - Pushes while full are not possible (cmd_ready=0).
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Empty → stay in IDLE.
  - Non-empty → pop the head into op registers.
  - If head ctrl==11 and b==00 → RESP with rsp_err=01, rsp_y=0, rsp_c=0; the ALU is not driven and alu_* keep their previous values.
  - Otherwise → ISSUE.
- ISSUE (exactly 1 cycle):
  - alu_a/alu_b/alu_ctrl take the op values at the IDLE→ISSUE edge.
  - alu_done is ignored (treated as stale from the previous op).
  - Next state is WAIT; the timeout counter clears to 0.
- WAIT:
  - Counter increments each cycle.
  - If alu_done=1 → capture alu_y/alu_c into rsp_y/rsp_c, set rsp_err=00, go to RESP.
  - Else if counter == TIMEOUT-1 → rsp_y=0, rsp_c=0, rsp_err=10, go to RESP.
  - alu_done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid=1; rsp_y/rsp_c/rsp_err are held stable.
  - On rsp_ready → rsp_valid=0 at the next edge and go to IDLE.
- alu_a/alu_b/alu_ctrl hold their last issued value in all states except on ISSUE entry.
- Latency (command pushed at edge 0 into an idle, empty block):
  - Pop/decision at edge 1.
  - Div-by-zero: rsp_valid high after edge 1.
  - ALU op: ISSUE after edge 1, WAIT after edge 2; rsp_valid high after the first WAIT edge that samples alu_done.
  - Back-to-back throughput: one command per (RESP exit + 3 + ALU latency) cycles.
- Ordering: responses are returned strictly in command order.
- All outputs are registered; no combinational path from any input to any output except cmd_ready (from the FIFO count only).

Decomposition:
- Package au_pkg holds:
  - Opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV.
  - Error codes ERR_OK/ERR_DIV0/ERR_TMO.
  - FSM state enum.
  - Packed command struct {a, b, ctrl}, 6 bits.
- One sub-module: au_cmd_fifo, a synchronous FIFO parameterised by DEPTH and width 6, with full/empty outputs and the same async active-low reset.

Test Plan:
1. ADD a=10 b=01; ALU model asserts done 2 cycles after the operands change, y=0011 → rsp_y=0011, rsp_c=0, rsp_err=00; alu_* = 10/01/00.
2. DIV a=10 b=00 ctrl=11 → rsp_err=01, rsp_y=0 one cycle after the pop; alu_* unchanged; the FSM never enters WAIT.
3. MUL a=10 b=11; ALU never asserts done → rsp_err=10 exactly TIMEOUT cycles after entering WAIT; the next queued SUB a=11 b=01 then completes with rsp_y=0010, rsp_err=00.
4. rsp_ready=0; present 6 commands back-to-back:
   - 5 are accepted (1 in flight, 4 buffered) and cmd_ready=0 on the 6th.
   - Then raise rsp_ready: all 5 responses return in order, cmd_ready reasserts, and the 6th is accepted.
5. reset asserted during WAIT of a MUL with 2 commands queued → all outputs 0 immediately; after release busy=0, cmd_ready=1, and no stale response appears.
6. Done coincident with the timeout cycle (done on the TIMEOUT-th WAIT cycle), MUL a=10 b=11, y=0110 → rsp_err=00, rsp_y=0110.
